// File: rtl/can_tx_stuff.sv
// CAN bit-stream transmitter: drives frame bits on tx at tx_point, inserting
// dynamic stuff bits and FD fixed stuff bits, and checks each driven bit at
// sample_point. All outputs are registered; tx/data_ready follow tx_point by one clk.
module can_tx_stuff (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_point,
  input  logic       sample_point,
  input  logic       sampled_bit,
  input  logic       tx_start,
  input  logic       abort,
  input  logic       data_bit,
  input  logic       data_last,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       stuff_en,
  input  logic       fixed_stuff,
  input  logic       arb,
  input  logic       ack_slot,
  output logic       tx,
  output logic       busy,
  output logic       bit_err,
  output logic       arb_lost,
  output logic [2:0] stuff_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STUFF} state_t;

  state_t     state_q, state_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       data_ready_q, data_ready_d;
  logic       bit_err_q, bit_err_d;
  logic       arb_lost_q, arb_lost_d;
  logic [2:0] stuff_cnt_q, stuff_cnt_d;
  logic [2:0] same_cnt_q, same_cnt_d;
  logic [2:0] fix_cnt_q, fix_cnt_d;
  logic       last_tx_q, last_tx_d;
  logic       pend_q, pend_d;          // a stuff bit goes out at the next tx_point
  logic       pend_dyn_q, pend_dyn_d;  // pending stuff is dynamic (counted) vs fixed
  logic       last_done_q, last_done_d;  // the data_last bit has been driven
  logic       fixed_prev_q, fixed_prev_d;  // fixed_stuff seen at the previous tx_point

  logic       fix_rise;
  logic       check;
  logic       lose_arb;
  logic [2:0] same_nxt;

  // Next-state: abort beats everything, then arbitration loss, then tx_point work.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    data_ready_d = 1'b0;
    bit_err_d    = 1'b0;
    arb_lost_d   = 1'b0;
    stuff_cnt_d  = stuff_cnt_q;
    same_cnt_d   = same_cnt_q;
    fix_cnt_d    = fix_cnt_q;
    last_tx_d    = last_tx_q;
    pend_d       = pend_q;
    pend_dyn_d   = pend_dyn_q;
    last_done_d  = last_done_q;
    fixed_prev_d = fixed_prev_q;
    // A rise after the last bit is irrelevant: the frame is already closing.
    fix_rise     = fixed_stuff & ~fixed_prev_q & ~last_done_q;
    check        = sample_point & busy_q & ~ack_slot;
    lose_arb     = check & arb & tx_q & ~sampled_bit;
    // Saturate so long unstuffed runs never wrap back through 5.
    same_nxt     = (data_bit != last_tx_q) ? 3'd1 :
                   (same_cnt_q == 3'd7)    ? 3'd7 : same_cnt_q + 3'd1;

    if (abort) begin
      state_d     = IDLE;
      tx_d        = 1'b1;
      pend_d      = 1'b0;
      last_done_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (tx_start) begin
        state_d      = RUN;
        same_cnt_d   = 3'd0;
        fix_cnt_d    = 3'd0;
        stuff_cnt_d  = 3'd0;
        last_tx_d    = 1'b1;
        pend_d       = 1'b0;
        pend_dyn_d   = 1'b0;
        last_done_d  = 1'b0;
        fixed_prev_d = 1'b0;
      end
    end else if (lose_arb) begin
      arb_lost_d  = 1'b1;
      state_d     = IDLE;
      tx_d        = 1'b1;
      pend_d      = 1'b0;
      last_done_d = 1'b0;
    end else begin
      // Other mismatches only flag; the bit-stream processor answers with abort.
      if (check && (sampled_bit != tx_q)) begin
        bit_err_d = 1'b1;
      end
      if (tx_point) begin
        fixed_prev_d = fixed_stuff;
        if (last_done_q && !pend_q) begin
          state_d     = IDLE;
          tx_d        = 1'b1;
          last_done_d = 1'b0;
        end else if (pend_q || fix_rise) begin
          state_d    = STUFF;
          tx_d       = ~last_tx_q;
          last_tx_d  = ~last_tx_q;
          same_cnt_d = 3'd1;
          pend_d     = 1'b0;
          if (pend_q && pend_dyn_q) begin
            stuff_cnt_d = stuff_cnt_q + 3'd1;
          end
          if (fix_rise || (pend_q && !pend_dyn_q)) begin
            fix_cnt_d = 3'd0;
          end
        end else if (data_valid) begin
          state_d      = RUN;
          tx_d         = data_bit;
          last_tx_d    = data_bit;
          data_ready_d = 1'b1;
          last_done_d  = data_last;
          same_cnt_d   = same_nxt;
          if (fixed_stuff) begin
            if (fix_cnt_q == 3'd3) begin
              pend_d     = 1'b1;
              pend_dyn_d = 1'b0;
              fix_cnt_d  = 3'd0;
            end else begin
              fix_cnt_d = fix_cnt_q + 3'd1;
            end
          end else if (stuff_en && (same_nxt == 3'd5)) begin
            pend_d     = 1'b1;
            pend_dyn_d = 1'b1;
          end
        end else begin
          // Underrun: hold recessive without touching the stuff counters.
          state_d = RUN;
          tx_d    = 1'b1;
        end
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
      bit_err_q    <= 1'b0;
      arb_lost_q   <= 1'b0;
      stuff_cnt_q  <= 3'd0;
      same_cnt_q   <= 3'd0;
      fix_cnt_q    <= 3'd0;
      last_tx_q    <= 1'b1;
      pend_q       <= 1'b0;
      pend_dyn_q   <= 1'b0;
      last_done_q  <= 1'b0;
      fixed_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      data_ready_q <= data_ready_d;
      bit_err_q    <= bit_err_d;
      arb_lost_q   <= arb_lost_d;
      stuff_cnt_q  <= stuff_cnt_d;
      same_cnt_q   <= same_cnt_d;
      fix_cnt_q    <= fix_cnt_d;
      last_tx_q    <= last_tx_d;
      pend_q       <= pend_d;
      pend_dyn_q   <= pend_dyn_d;
      last_done_q  <= last_done_d;
      fixed_prev_q <= fixed_prev_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign data_ready = data_ready_q;
  assign bit_err    = bit_err_q;
  assign arb_lost   = arb_lost_q;
  assign stuff_cnt  = stuff_cnt_q;

endmodule

// File: tb/tb_can_tx_stuff.sv
// Randomised and directed bench for can_tx_stuff: a reference model expands
// each frame into the expected bus bit stream, a monitor compares at tx_point.
module tb_can_tx_stuff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_point = 1'b0, sample_point = 1'b0, sampled_bit = 1'b1;
  logic       tx_start = 1'b0, abort = 1'b0;
  logic       data_bit = 1'b0, data_last = 1'b0, data_valid = 1'b0;
  logic       stuff_en = 1'b0, fixed_stuff = 1'b0, arb = 1'b0, ack_slot = 1'b0;
  logic       data_ready, tx, busy, bit_err, arb_lost;
  logic [2:0] stuff_cnt;

  typedef struct packed { logic tx; logic dr; logic busy; } exp_t;
  exp_t exp_q[$];

  logic src_bits [0:63];
  int   src_n = 0;
  int   src_fix = -1;
  int   cons = 0;
  int   ph = 0;
  logic inj_flip = 1'b0;
  int   n_be = 0, n_al = 0;
  int   checks = 0, failures = 0;

  can_tx_stuff dut (
    .clk(clk), .rst(rst), .tx_point(tx_point), .sample_point(sample_point),
    .sampled_bit(sampled_bit), .tx_start(tx_start), .abort(abort),
    .data_bit(data_bit), .data_last(data_last), .data_valid(data_valid),
    .data_ready(data_ready), .stuff_en(stuff_en), .fixed_stuff(fixed_stuff),
    .arb(arb), .ack_slot(ack_slot), .tx(tx), .busy(busy), .bit_err(bit_err),
    .arb_lost(arb_lost), .stuff_cnt(stuff_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit timing: 8 clk per bit, bus echoes tx unless a flip is injected.
  always @(negedge clk) begin
    ph = (ph == 7) ? 0 : ph + 1;
    tx_point = (ph == 0);
    sample_point = (ph == 5);
    sampled_bit = tx ^ inj_flip;
  end

  // Frame bit source, advanced by data_ready.
  always @(negedge clk) begin
    if (tx_start) cons = 0;
    else if (data_ready) cons = cons + 1;
    data_valid  = (cons < src_n);
    data_bit    = src_bits[(cons < 64) ? cons : 0];
    data_last   = (cons == src_n - 1);
    fixed_stuff = (src_fix >= 0) && (cons >= src_fix);
  end

  always @(posedge clk) begin
    #1;
    if (bit_err) n_be++;
    if (arb_lost) n_al++;
  end

  // Scoreboard monitor: every tx_point during a modelled frame pops one bit.
  always @(posedge clk) begin : mon
    logic tp;
    exp_t e;
    tp = tx_point;
    #1;
    if (tp && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_tx", tx, e.tx);
      chk("sb_data_ready", data_ready, e.dr);
      chk("sb_busy", busy, e.busy);
    end
  end

  // Reference: expand the frame into the bus bit stream at tx_point granularity.
  task automatic model_frame(output logic [2:0] scnt_o);
    logic em[$];
    int   used = 0, pend = 0, fixc = 0, scnt = 0, run;
    bit   prev = 0, done = 0, fs, rise;
    logic b, last = 1'b1;
    exp_t e;
    for (int step = 0; step < 200; step++) begin
      fs = (src_fix >= 0) && (used >= src_fix);
      rise = fs && !prev && !done;
      prev = fs;
      if (done && pend == 0) begin
        e = '{1'b1, 1'b0, 1'b0};
        exp_q.push_back(e);
        break;
      end
      if (pend != 0 || rise) begin
        b = ~last;
        if (pend == 1) scnt++;
        if (rise || pend == 2) fixc = 0;
        pend = 0;
        e = '{b, 1'b0, 1'b1};
      end else begin
        b = src_bits[used];
        used++;
        e = '{b, 1'b1, 1'b1};
        run = 1;
        for (int k = em.size() - 1; k >= 0 && em[k] == b; k--) run++;
        if (fs) begin
          fixc++;
          if (fixc == 4) begin pend = 2; fixc = 0; end
        end else if (stuff_en && run == 5) begin
          pend = 1;
        end
        done = (used == src_n);
      end
      em.push_back(b);
      exp_q.push_back(e);
      last = b;
    end
    scnt_o = 3'(scnt % 8);
  endtask

  task automatic wait_ph(input int p);
    int guard = 0;
    do begin @(negedge clk); #2; guard++; end while (ph != p && guard < 20);
  endtask

  task automatic start_raw();
    wait_ph(3);
    tx_start = 1'b1;
    @(negedge clk); #2;
    tx_start = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit se, input int fs_at);
    logic [2:0] exp_sc;
    int guard = 0;
    int be0;
    src_n = n; src_fix = fs_at; stuff_en = se;
    wait_ph(3);
    be0 = n_be;
    model_frame(exp_sc);
    tx_start = 1'b1;
    @(negedge clk); #2;
    tx_start = 1'b0;
    while (exp_q.size() > 0 && guard < 2000) begin @(negedge clk); guard++; end
    if (exp_q.size() > 0) begin
      chk("frame_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
    chk("frame_stuff_cnt", stuff_cnt, exp_sc);
    chk("frame_busy_end", busy, 0);
    chk("frame_no_bit_err", n_be - be0, 0);
  endtask

  task automatic do_abort();
    @(negedge clk); #2; abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_tx", tx, 1);
    @(negedge clk); #2; abort = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, fsat, be0;
    logic b;
    #1 rst = 1'b1;
    #2;
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_data_ready", data_ready, 0);
    chk("rst_bit_err", bit_err, 0); chk("rst_arb_lost", arb_lost, 0);
    chk("rst_stuff_cnt", stuff_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Dynamic stuff after five zeros.
    for (int k = 0; k < 6; k++) src_bits[k] = (k == 5);
    run_frame(6, 1'b1, -1);
    chk("dyn_stuff_cnt_is_1", stuff_cnt, 1);

    // Fixed stuff on a rising fixed_stuff after a recessive bit.
    src_bits[0] = 1; src_bits[1] = 1; src_bits[2] = 0;
    src_bits[3] = 1; src_bits[4] = 0; src_bits[5] = 1;
    run_frame(6, 1'b1, 1);
    chk("fixed_stuff_cnt_is_0", stuff_cnt, 0);

    // Single-bit frame.
    src_bits[0] = 0;
    run_frame(1, 1'b1, -1);

    // Randomised frames with long runs to exercise stuffing.
    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 40);
      b = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        src_bits[k] = b;
      end
      fsat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
      run_frame(n, $urandom_range(0, 3) != 0, fsat);
    end

    // Arbitration loss: drive 1, bus reads 0.
    for (int k = 0; k < 4; k++) src_bits[k] = 1;
    src_n = 4; src_fix = -1; stuff_en = 1'b1; arb = 1'b1;
    be0 = n_be;
    start_raw();
    wait_ph(0); wait_ph(4); inj_flip = 1'b1; wait_ph(5);
    @(posedge clk); #1;
    chk("arb_lost_pulse", arb_lost, 1);
    chk("arb_busy", busy, 0);
    chk("arb_tx", tx, 1);
    chk("arb_no_bit_err", n_be - be0, 0);
    @(negedge clk); #2; inj_flip = 1'b0; arb = 1'b0;

    // Bit error: drive 0, bus reads 1.
    for (int k = 0; k < 4; k++) src_bits[k] = 0;
    start_raw();
    wait_ph(0); wait_ph(4);
    chk("be_tx_driven", tx, 0);
    inj_flip = 1'b1; wait_ph(5);
    @(posedge clk); #1;
    chk("bit_err_pulse", bit_err, 1);
    chk("bit_err_busy_held", busy, 1);
    chk("bit_err_no_arb", arb_lost, 0);
    @(negedge clk); #2; inj_flip = 1'b0;
    do_abort();

    // Same mismatch in the ACK slot is not an error.
    ack_slot = 1'b1;
    be0 = n_be;
    start_raw();
    wait_ph(0); wait_ph(4); inj_flip = 1'b1; wait_ph(5);
    @(posedge clk); #1;
    @(negedge clk); #2; inj_flip = 1'b0;
    chk("ack_no_bit_err", n_be - be0, 0);
    ack_slot = 1'b0;
    do_abort();

    // Abort coincident with tx_point.
    start_raw();
    wait_ph(0); wait_ph(0);
    chk("abort_pre_tx", tx, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_tp_tx", tx, 1);
    chk("abort_tp_data_ready", data_ready, 0);
    chk("abort_tp_busy", busy, 0);
    @(negedge clk); #2; abort = 1'b0;

    // Reset during a stuff bit releases the bus at once, no resume.
    for (int k = 0; k < 7; k++) src_bits[k] = 1;
    src_n = 7; stuff_en = 1'b1;
    start_raw();
    repeat (6) wait_ph(0);
    @(posedge clk); #1;
    chk("stuff_slot_tx", tx, 0);
    chk("stuff_slot_no_ready", data_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); #2 rst = 1'b0;
    repeat (24) @(negedge clk);
    chk("no_resume_busy", busy, 0);
    chk("no_resume_tx", tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
